vmem_fill_ctrl: RTL and testbench
=================================

// Module: vmem_fill_ctrl
// PURPOSE
//  Hardware rectangle-fill engine and write-port arbiter for the 240x240 RGB111 video memory.
//  The CPU programs a rectangle and a colour over a small register window on the data bus, then starts the fill.
//  The engine rasters the pixel writes into the single vmem write port. Direct CPU vmem stores always win the port.
//  Sits between the CPU dbus decode and vmem; display scan-out on the vmem read port is unaffected.
// PARAMETERS
//  WIDTH    240  visible columns; x in [0,WIDTH-1]
//  HEIGHT   240  visible rows; y in [0,HEIGHT-1]
//  COLOR_W  3    pixel width in bits (R,G,B one bit each)
// PORTS
//  clk_i         in   1        system clock
//  rst_ni        in   1        asynchronous active-low reset
//  cfg_we_i      in   1        register write strobe (dbus decode)
//  cfg_addr_i    in   5        register byte offset; [1:0] ignored
//  cfg_wdata_i   in   32       register write data
//  cfg_rdata_o   out  32       register read data, 1-cycle latency
//  cpu_we_i      in   1        direct CPU vmem store
//  cpu_waddr_i   in   16       {y[7:0],x[7:0]}
//  cpu_wdata_i   in   COLOR_W  CPU pixel colour
//  vmem_we_o     out  1        to vmem write enable (registered)
//  vmem_waddr_o  out  16       {y,x} to vmem (registered)
//  vmem_wdata_o  out  COLOR_W  to vmem (registered)
//  busy_o        out  1        fill in progress
//  done_o        out  1        one-cycle pulse on completion or reject
// BEHAVIOUR
//  Regs: 0x00 CTRL W:[0]start [1]abort; R:[0]busy [1]err(sticky) [2]done(sticky). Any CTRL write clears done/err first.
//        0x04 P0 {y0[23:16],x0[7:0]}; 0x08 P1 {y1,x1}, inclusive; 0x0C COLOR [COLOR_W-1:0].
//  P0/P1/COLOR writes while busy are ignored. Reads: cfg_rdata_o registered every cycle from cfg_addr_i; unused bits 0.
//  Reset: FSM IDLE; all outputs 0; P0=P1=0; COLOR=0; err=done=0.
//  FSM IDLE -> CHECK on start. CHECK: if x0>x1 | y0>y1 | x1>=WIDTH | y1>=HEIGHT: set err, pulse done_o, return to IDLE.
//  CHECK otherwise: x=x0, y=y0 -> FILL. FILL writes one pixel per granted cycle.
//  Raster: x++; at x==x1: x=x0, y++. After (x1,y1) is written -> DONE (done_o=1, done bit set) -> IDLE.
//  busy_o=1 in CHECK, FILL and DONE. done_o is high only in the DONE cycle or the reject cycle.
//  Arbitration: cpu_we_i=1 -> CPU write registered to vmem_* next cycle; fill counters hold that cycle (no pixel lost).
//  Fill write latency: 1 cycle from grant to vmem_we_o.
//  Abort in any busy state -> IDLE next cycle; the in-flight registered write still completes; no done pulse.
//  Start and abort set together: abort wins. Start while busy is ignored.
//  A 1x1 rectangle writes exactly 1 pixel. Full screen = 57600 writes, min 57600+3 cycles.
//  Async reset mid-fill: immediate IDLE; vmem_we_o drops at once.
// CONFIGURATION
//  FILL_STATS_EN defined: reg 0x10 STALLS is a 32-bit count of FILL cycles lost to CPU priority.
//   STALLS is cleared on start and saturates at 0xFFFF_FFFF.
//  FILL_STATS_EN undefined: 0x10 reads 0; no counter is synthesised.
// STRUCTURE
//  config.vh: FILL_REG_CTRL/P0/P1/COLOR/STALLS offsets, FILL_ST_IDLE/CHECK/FILL/DONE encodings, LCD_W/LCD_H.
//  Sub-module fill_raster_cnt: x/y counters with load(x0,y0), step, bounds (x0,x1,y1) -> last flag.
//  Top holds the FSM, registers and arbiter mux.
// TESTING
//  P0=(2,3),P1=(4,4),COLOR=5,start -> 6 writes in order (2,3)(3,3)(4,3)(2,4)(3,4)(4,4), data 5, then done_o 1 cycle.
//  P0=P1=(239,239),start -> single write addr 0xEFEF, done; CTRL read = 0x4.
//  P0=(10,0),P1=(5,0),start -> no vmem writes, done_o pulse, CTRL read err=1,busy=0.
//  Full-screen fill with cpu_we_i high every 4th cycle -> 57600 fill writes plus all CPU writes bit-exact.
//   With FILL_STATS_EN: STALLS equals the CPU-write count during FILL.
//  Abort after 100 fill writes -> busy_o low next cycle, exactly 100-101 fill writes, no done_o.
//  Start again: fill runs normally.
//  Assert rst_ni low mid-fill -> vmem_we_o=0 immediately; after release CTRL reads 0 and P0/P1 read 0.

Source files
------------

// File: rtl/vmem_fill_ctrl_pkg.sv
// Shared types and constants for the vmem rectangle-fill engine.
// Register offsets, FSM encoding, screen geometry and point layout.
package vmem_fill_ctrl_pkg;

  localparam int LCD_W = 240;
  localparam int LCD_H = 240;
  localparam int PIX_W = 3;

  localparam logic [2:0] FILL_REG_CTRL   = 3'd0;
  localparam logic [2:0] FILL_REG_P0     = 3'd1;
  localparam logic [2:0] FILL_REG_P1     = 3'd2;
  localparam logic [2:0] FILL_REG_COLOR  = 3'd3;
  localparam logic [2:0] FILL_REG_STALLS = 3'd4;

  typedef enum logic [1:0] {
    FILL_ST_IDLE  = 2'd0,
    FILL_ST_CHECK = 2'd1,
    FILL_ST_FILL  = 2'd2,
    FILL_ST_DONE  = 2'd3
  } fill_st_e;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] x;
  } pt_t;

  function automatic logic [31:0] pt_to_reg(pt_t p);
    return {8'h00, p.y, 8'h00, p.x};
  endfunction

endpackage

// File: rtl/vmem_fill_ctrl_if.sv
// Registered vmem write port driven by the fill controller.
// master = controller side, slave = video memory side.
interface vmem_fill_ctrl_if #(
  parameter int COLOR_W = 3
);

  logic               we;
  logic [15:0]        waddr;
  logic [COLOR_W-1:0] wdata;

  modport master (output we, waddr, wdata);
  modport slave  (input  we, waddr, wdata);

endinterface

// File: rtl/vmem_fill_ctrl_raster_cnt.sv
// Raster x/y position counter for the fill engine.
// Loads the top-left corner, steps left-to-right then top-to-bottom.
module vmem_fill_ctrl_raster_cnt
  import vmem_fill_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic step_i,
  input  pt_t  p0_i,
  input  pt_t  p1_i,
  output pt_t  pos_o,
  output logic last_o
);

  pt_t pos_q, pos_d;

  always_comb begin
    pos_d = pos_q;
    if (load_i) begin
      pos_d = p0_i;
    end else if (step_i) begin
      if (pos_q.x == p1_i.x) begin
        pos_d.x = p0_i.x;
        pos_d.y = pos_q.y + 8'd1;
      end else begin
        pos_d.x = pos_q.x + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos_o  = pos_q;
  assign last_o = (pos_q == p1_i);

endmodule

// File: rtl/vmem_fill_ctrl.sv
// Rectangle-fill engine and vmem write-port arbiter (CPU stores win).
// Optional FILL_STATS_EN adds the STALLS counter at offset 0x10.
module vmem_fill_ctrl
  import vmem_fill_ctrl_pkg::*;
#(
  parameter int WIDTH   = LCD_W,
  parameter int HEIGHT  = LCD_H,
  parameter int COLOR_W = PIX_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cfg_we_i,
  input  logic [4:0]         cfg_addr_i,
  input  logic [31:0]        cfg_wdata_i,
  output logic [31:0]        cfg_rdata_o,
  input  logic               cpu_we_i,
  input  logic [15:0]        cpu_waddr_i,
  input  logic [COLOR_W-1:0] cpu_wdata_i,
  vmem_fill_ctrl_if.master   vmem,
  output logic               busy_o,
  output logic               done_o
);

  localparam logic [7:0] LastX = 8'(WIDTH - 1);
  localparam logic [7:0] LastY = 8'(HEIGHT - 1);

  fill_st_e state_q, state_d;

  pt_t p0_q, p0_d;
  pt_t p1_q, p1_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic err_q, err_d;
  logic done_q, done_d;
  logic [31:0] rdata_q, rdata_d;

  logic               vm_we_q, vm_we_d;
  logic [15:0]        vm_addr_q, vm_addr_d;
  logic [COLOR_W-1:0] vm_data_q, vm_data_d;

  logic [2:0] reg_sel;
  logic ctrl_wr, start_req, abort_req;
  logic busy, bad_rect;
  logic load, grant, done_pulse;
  pt_t  pos;
  logic last;

  assign reg_sel   = cfg_addr_i[4:2];
  assign ctrl_wr   = cfg_we_i && (reg_sel == FILL_REG_CTRL);
  assign start_req = ctrl_wr && cfg_wdata_i[0];
  assign abort_req = ctrl_wr && cfg_wdata_i[1];
  assign busy      = (state_q != FILL_ST_IDLE);

  assign bad_rect = (p0_q.x > p1_q.x) || (p0_q.y > p1_q.y) ||
                    (p1_q.x > LastX)  || (p1_q.y > LastY);

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    done_d     = done_q;
    load       = 1'b0;
    grant      = 1'b0;
    done_pulse = 1'b0;
    if (ctrl_wr) begin
      err_d  = 1'b0;
      done_d = 1'b0;
    end
    unique case (state_q)
      FILL_ST_IDLE: begin
        if (start_req && !abort_req) state_d = FILL_ST_CHECK;
      end
      FILL_ST_CHECK: begin
        if (bad_rect) begin
          err_d      = 1'b1;
          done_d     = 1'b1;
          done_pulse = 1'b1;
          state_d    = FILL_ST_IDLE;
        end else begin
          load    = 1'b1;
          state_d = FILL_ST_FILL;
        end
      end
      FILL_ST_FILL: begin
        if (!cpu_we_i) begin
          grant = 1'b1;
          if (last) state_d = FILL_ST_DONE;
        end
      end
      FILL_ST_DONE: begin
        done_d     = 1'b1;
        done_pulse = 1'b1;
        state_d    = FILL_ST_IDLE;
      end
      default: state_d = FILL_ST_IDLE;
    endcase
    // Abort squashes any pending grant, load or completion this cycle.
    if (abort_req && busy) begin
      state_d    = FILL_ST_IDLE;
      grant      = 1'b0;
      load       = 1'b0;
      done_pulse = 1'b0;
      err_d      = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_comb begin
    p0_d    = p0_q;
    p1_d    = p1_q;
    color_d = color_q;
    if (cfg_we_i && !busy) begin
      unique case (1'b1)
        reg_sel == FILL_REG_P0: begin
          p0_d = '{y: cfg_wdata_i[23:16], x: cfg_wdata_i[7:0]};
        end
        reg_sel == FILL_REG_P1: begin
          p1_d = '{y: cfg_wdata_i[23:16], x: cfg_wdata_i[7:0]};
        end
        reg_sel == FILL_REG_COLOR: begin
          color_d = cfg_wdata_i[COLOR_W-1:0];
        end
        default: ;
      endcase
    end
  end

  vmem_fill_ctrl_raster_cnt u_raster (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (load),
    .step_i (grant),
    .p0_i   (p0_q),
    .p1_i   (p1_q),
    .pos_o  (pos),
    .last_o (last)
  );

  always_comb begin
    vm_we_d   = cpu_we_i || grant;
    vm_addr_d = cpu_we_i ? cpu_waddr_i : {pos.y, pos.x};
    vm_data_d = cpu_we_i ? cpu_wdata_i : color_q;
  end

`ifdef FILL_STATS_EN
  logic [31:0] stalls_q, stalls_d;

  always_comb begin
    stalls_d = stalls_q;
    if (state_q == FILL_ST_IDLE && start_req && !abort_req) begin
      stalls_d = '0;
    end else if (state_q == FILL_ST_FILL && cpu_we_i &&
                 stalls_q != 32'hFFFF_FFFF) begin
      stalls_d = stalls_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stalls_q <= '0;
    else         stalls_q <= stalls_d;
  end
`endif

  always_comb begin
    rdata_d = '0;
    unique case (1'b1)
      reg_sel == FILL_REG_CTRL:  rdata_d = {29'd0, done_q, err_q, busy};
      reg_sel == FILL_REG_P0:    rdata_d = pt_to_reg(p0_q);
      reg_sel == FILL_REG_P1:    rdata_d = pt_to_reg(p1_q);
      reg_sel == FILL_REG_COLOR: rdata_d[COLOR_W-1:0] = color_q;
`ifdef FILL_STATS_EN
      reg_sel == FILL_REG_STALLS: rdata_d = stalls_q;
`endif
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= FILL_ST_IDLE;
      p0_q      <= '0;
      p1_q      <= '0;
      color_q   <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
      vm_we_q   <= 1'b0;
      vm_addr_q <= '0;
      vm_data_q <= '0;
    end else begin
      state_q   <= state_d;
      p0_q      <= p0_d;
      p1_q      <= p1_d;
      color_q   <= color_d;
      err_q     <= err_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      vm_we_q   <= vm_we_d;
      vm_addr_q <= vm_addr_d;
      vm_data_q <= vm_data_d;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{cfg_addr_i[1:0], cfg_wdata_i[31:24],
                       cfg_wdata_i[15:8]};

  assign cfg_rdata_o = rdata_q;
  assign vmem.we     = vm_we_q;
  assign vmem.waddr  = vm_addr_q;
  assign vmem.wdata  = vm_data_q;
  assign busy_o      = busy;
  assign done_o      = done_pulse;

endmodule

// File: tb/tb_vmem_fill_ctrl.sv
// Randomized self-checking bench for vmem_fill_ctrl.
// Reference: raster pixel lists per rectangle plus a CPU write log.
module tb_vmem_fill_ctrl;
  import vmem_fill_ctrl_pkg::*;

  typedef logic [18:0] wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic [31:0] cfg_rdata;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_waddr = '0;
  logic [2:0]  cpu_wdata = '0;
  logic        busy, done;

  vmem_fill_ctrl_if #(.COLOR_W(3)) vm();

  vmem_fill_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cfg_we_i    (cfg_we),
    .cfg_addr_i  (cfg_addr),
    .cfg_wdata_i (cfg_wdata),
    .cfg_rdata_o (cfg_rdata),
    .cpu_we_i    (cpu_we),
    .cpu_waddr_i (cpu_waddr),
    .cpu_wdata_i (cpu_wdata),
    .vmem        (vm),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  wr_t fill_q[$];
  wr_t cpu_obs_q[$];
  wr_t cpu_exp_q[$];
  wr_t exp_q[$];
  int  done_cnt = 0;
  int  cpu_lost = 0;

  logic pcw = 1'b0;
  wr_t  pcv = '0;

  always @(posedge clk) begin
    pcw <= cpu_we;
    pcv <= {cpu_waddr, cpu_wdata};
  end

  // A write seen now belongs to the CPU iff the CPU stored last edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt = done_cnt + 1;
      if (vm.we) begin
        if (pcw) cpu_obs_q.push_back({vm.waddr, vm.wdata});
        else     fill_q.push_back({vm.waddr, vm.wdata});
      end else if (pcw) begin
        cpu_lost = cpu_lost + 1;
      end
    end
  end

  task automatic cfg_wr(input logic [4:0] a, input logic [31:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic cfg_rd(input logic [4:0] a, output logic [31:0] d);
    cfg_addr = a;
    @(negedge clk);
    d = cfg_rdata;
  endtask

  task automatic set_rect(input int x0, input int y0, input int x1,
                          input int y1, input int col);
    cfg_wr(5'h04, {8'h0, 8'(y0), 8'h0, 8'(x0)});
    cfg_wr(5'h08, {8'h0, 8'(y1), 8'h0, 8'(x1)});
    cfg_wr(5'h0C, 32'(col));
  endtask

  function automatic void build_exp(input int x0, input int y0,
                                    input int x1, input int y1,
                                    input int col);
    exp_q.delete();
    if (x0 <= x1 && y0 <= y1 && x1 < LCD_W && y1 < LCD_H)
      for (int y = y0; y <= y1; y++)
        for (int x = x0; x <= x1; x++)
          exp_q.push_back({8'(y), 8'(x), 3'(col)});
  endfunction

  function automatic int fill_diff(input int base);
    if (fill_q.size() - base != exp_q.size()) return -2;
    for (int i = 0; i < exp_q.size(); i++)
      if (fill_q[base + i] !== exp_q[i]) return i;
    return -1;
  endfunction

  function automatic int cpu_diff();
    if (cpu_obs_q.size() != cpu_exp_q.size()) return -2;
    for (int i = 0; i < cpu_exp_q.size(); i++)
      if (cpu_obs_q[i] !== cpu_exp_q[i]) return i;
    return -1;
  endfunction

  // mode 0: no CPU, 1: every 4th cycle, 2: random ~1/3
  task automatic run_fill(input int mode, input int limit,
                          output int cycles, output int stall_exp);
    int left;
    left = exp_q.size();
    stall_exp = 0;
    cycles = 0;
    cfg_wr(5'h00, 32'h1);
    while (busy && cycles < limit) begin
      if (mode == 1)      cpu_we = (cycles % 4 == 0);
      else if (mode == 2) cpu_we = ($urandom % 3 == 0);
      else                cpu_we = 1'b0;
      if (cpu_we) begin
        cpu_waddr = 16'($urandom);
        cpu_wdata = 3'($urandom);
        cpu_exp_q.push_back({cpu_waddr, cpu_wdata});
      end
      if (cycles >= 1 && left > 0) begin
        if (cpu_we) stall_exp++;
        else        left--;
      end
      @(negedge clk);
      cycles++;
    end
    cpu_we = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL fill_timeout busy=%b after %0d cycles", busy, cycles);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [4:0] a;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({vm.we, busy, done, cfg_rdata} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs got we=%b busy=%b done=%b rd=%h exp 0",
               vm.we, busy, done, cfg_rdata);
    end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      a = 5'(i * 4);
      cfg_rd(a, d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL reset_reg_%0h got %h exp 0", a, d);
      end
    end
  endtask

  task automatic test_spec_rect();
    int fb, db, cyc, st;
    logic [31:0] d;
    set_rect(2, 3, 4, 4, 5);
    build_exp(2, 3, 4, 4, 5);
    fb = fill_q.size();
    db = done_cnt;
    run_fill(0, 200, cyc, st);
    checks++;
    if (fill_diff(fb) != -1) begin
      errors++;
      $display("FAIL rect_writes got n=%0d diff=%0d exp n=6",
               fill_q.size() - fb, fill_diff(fb));
    end
    checks++;
    if (done_cnt - db != 1) begin
      errors++;
      $display("FAIL rect_done got %0d cycles exp 1", done_cnt - db);
    end
    checks++;
    if (cyc != 8) begin
      errors++;
      $display("FAIL rect_busy_cycles got %0d exp 8", cyc);
    end
    cfg_rd(5'h00, d);
    checks++;
    if (d !== 32'h4) begin
      errors++;
      $display("FAIL rect_ctrl got %h exp 4", d);
    end
  endtask

  task automatic test_single_pixel();
    int fb, db, cyc, st;
    logic [31:0] d;
    set_rect(239, 239, 239, 239, 6);
    build_exp(239, 239, 239, 239, 6);
    fb = fill_q.size();
    db = done_cnt;
    run_fill(0, 50, cyc, st);
    checks++;
    if (fill_q.size() - fb != 1 || fill_q[fb][18:3] !== 16'hEFEF ||
        fill_diff(fb) != -1) begin
      errors++;
      $display("FAIL pixel_1x1 got n=%0d exp n=1 addr efef",
               fill_q.size() - fb);
    end
    checks++;
    if (done_cnt - db != 1) begin
      errors++;
      $display("FAIL pixel_done got %0d exp 1", done_cnt - db);
    end
    cfg_rd(5'h00, d);
    checks++;
    if (d !== 32'h4) begin
      errors++;
      $display("FAIL pixel_ctrl got %h exp 4", d);
    end
  endtask

  task automatic test_reject();
    int fb, db, cyc, st;
    logic [31:0] d;
    int r[3][4] = '{'{10, 0, 5, 0}, '{0, 5, 3, 2}, '{0, 0, 240, 5}};
    for (int k = 0; k < 3; k++) begin
      set_rect(r[k][0], r[k][1], r[k][2], r[k][3], 1);
      fb = fill_q.size();
      db = done_cnt;
      exp_q.delete();
      run_fill(0, 20, cyc, st);
      checks++;
      if (fill_q.size() != fb || done_cnt - db != 1) begin
        errors++;
        $display("FAIL reject_%0d got writes=%0d done=%0d exp 0 and 1",
                 k, fill_q.size() - fb, done_cnt - db);
      end
      cfg_rd(5'h00, d);
      checks++;
      if (d[1:0] !== 2'b10) begin
        errors++;
        $display("FAIL reject_ctrl_%0d got %h exp err=1 busy=0", k, d);
      end
    end
  endtask

  task automatic test_random_rects(input int n);
    int fb, db, cyc, st, x0, y0, x1, y1, c;
    for (int k = 0; k < n; k++) begin
      x0 = $urandom_range(0, 230);
      y0 = $urandom_range(0, 235);
      x1 = x0 + $urandom_range(0, 9);
      y1 = y0 + $urandom_range(0, 4);
      c  = $urandom_range(0, 7);
      set_rect(x0, y0, x1, y1, c);
      build_exp(x0, y0, x1, y1, c);
      fb = fill_q.size();
      db = done_cnt;
      run_fill(2, 2000, cyc, st);
      checks++;
      if (fill_diff(fb) != -1 || done_cnt - db != 1) begin
        errors++;
        $display("FAIL rand_%0d got n=%0d diff=%0d done=%0d exp n=%0d",
                 k, fill_q.size() - fb, fill_diff(fb),
                 done_cnt - db, exp_q.size());
      end
      checks++;
      if (cyc != 2 + exp_q.size() + st) begin
        errors++;
        $display("FAIL rand_cycles_%0d got %0d exp %0d", k, cyc,
                 2 + exp_q.size() + st);
      end
    end
    checks++;
    if (cpu_diff() != -1 || cpu_lost != 0) begin
      errors++;
      $display("FAIL rand_cpu got diff=%0d lost=%0d exp -1 and 0",
               cpu_diff(), cpu_lost);
    end
  endtask

  task automatic test_full_screen();
    int fb, db, cyc, st;
    logic [31:0] d;
    set_rect(0, 0, 239, 239, 3);
    build_exp(0, 0, 239, 239, 3);
    fb = fill_q.size();
    db = done_cnt;
    run_fill(1, 90000, cyc, st);
    checks++;
    if (fill_diff(fb) != -1 || done_cnt - db != 1) begin
      errors++;
      $display("FAIL full_writes got n=%0d diff=%0d done=%0d exp 57600",
               fill_q.size() - fb, fill_diff(fb), done_cnt - db);
    end
    checks++;
    if (cyc != 57602 + st) begin
      errors++;
      $display("FAIL full_cycles got %0d exp %0d", cyc, 57602 + st);
    end
    checks++;
    if (cpu_diff() != -1 || cpu_lost != 0) begin
      errors++;
      $display("FAIL full_cpu got diff=%0d lost=%0d exp -1 and 0",
               cpu_diff(), cpu_lost);
    end
    cfg_rd(5'h10, d);
    checks++;
`ifdef FILL_STATS_EN
    if (d !== 32'(st)) begin
      errors++;
      $display("FAIL full_stalls got %0d exp %0d", d, st);
    end
`else
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL full_stalls got %0d exp 0", d);
    end
`endif
  endtask

  task automatic test_abort();
    int fb, db, n, t;
    logic [31:0] d;
    set_rect(0, 0, 239, 9, 2);
    build_exp(0, 0, 239, 9, 2);
    fb = fill_q.size();
    db = done_cnt;
    cfg_wr(5'h00, 32'h1);
    t = 0;
    while (fill_q.size() - fb < 100 && t < 500) begin
      @(negedge clk);
      #1;
      t++;
    end
    cfg_wr(5'h00, 32'h2);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy got %b exp 0", busy);
    end
    repeat (4) @(negedge clk);
    n = fill_q.size() - fb;
    checks++;
    if (n < 100 || n > 101 || done_cnt != db) begin
      errors++;
      $display("FAIL abort_count got n=%0d done=%0d exp 100..101 and 0",
               n, done_cnt - db);
    end
    t = 0;
    for (int i = 0; i < n && i < exp_q.size(); i++)
      if (fill_q[fb + i] !== exp_q[i]) t++;
    checks++;
    if (t != 0) begin
      errors++;
      $display("FAIL abort_order got %0d bad pixels exp 0", t);
    end
    cfg_rd(5'h00, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL abort_ctrl got %h exp 0", d);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] d;
    logic we_before;
    set_rect(0, 0, 239, 239, 7);
    cfg_wr(5'h00, 32'h1);
    repeat (50) @(negedge clk);
    @(posedge clk);
    #2 we_before = vm.we;
    rst_n = 1'b0;
    #1;
    checks++;
    if (we_before !== 1'b1 || vm.we !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got before=%b we=%b busy=%b exp 1 0 0",
               we_before, vm.we, busy);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    cfg_rd(5'h00, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_ctrl got %h exp 0", d);
    end
    cfg_rd(5'h04, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_p0 got %h exp 0", d);
    end
    cfg_rd(5'h08, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_p1 got %h exp 0", d);
    end
  endtask

  initial begin
    test_reset();
    test_spec_rect();
    test_single_pixel();
    test_reject();
    test_random_rects(6);
    test_full_screen();
    test_abort();
    test_random_rects(2);
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
